// File: rtl/fir_tap_sequencer.sv
// Sequencer driving a 2R/2W register file that holds the FIR delay line as a circular buffer.
// Writes each accepted sample, then reads the delay line back as symmetric tap pairs.
module fir_tap_sequencer #(
  parameter int N_TAPS = 8,
  parameter int BASE   = 1,
  parameter int W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         rf_we1,
  output logic         rf_we2,
  output logic [3:0]   rf_wa1,
  output logic [3:0]   rf_wa2,
  output logic [W-1:0] rf_wd1,
  output logic [W-1:0] rf_wd2,
  output logic [3:0]   rf_a1,
  output logic [3:0]   rf_a2,
  input  logic [W-1:0] rf_rd1,
  input  logic [W-1:0] rf_rd2,
  output logic         p_valid,
  input  logic         p_ready,
  output logic [W-1:0] p_new,
  output logic [W-1:0] p_old,
  output logic [3:0]   p_idx,
  output logic         p_last,
  output logic         busy
);

  typedef enum logic [1:0] {CLEAR, IDLE, WRITE, READ} state_t;

  localparam logic [3:0] BASE_A    = 4'(BASE);
  localparam logic [3:0] PTR_LAST  = 4'(N_TAPS - 1);
  localparam logic [2:0] HALF_LAST = 3'(N_TAPS / 2 - 1);
  localparam logic [4:0] N_MOD     = 5'(N_TAPS);

  state_t         state, state_next;
  logic [3:0]     ptr;
  logic [2:0]     j, k;
  logic [W-1:0]   sample;
  logic [4:0]     new_sum, old_sum;
  logic [3:0]     new_slot, old_slot;
  logic           pair_last;

  // Both sums stay below 2*N_TAPS, so a single conditional subtract is the modulo.
  always_comb begin
    new_sum   = {1'b0, ptr} + N_MOD - {2'b0, k};
    old_sum   = {1'b0, ptr} + 5'd1 + {2'b0, k};
    new_slot  = (new_sum >= N_MOD) ? 4'(new_sum - N_MOD) : new_sum[3:0];
    old_slot  = (old_sum >= N_MOD) ? 4'(old_sum - N_MOD) : old_sum[3:0];
    pair_last = (k == HALF_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      j      <= '0;
      k      <= '0;
      sample <= '0;
    end else begin
      case (state)
        CLEAR: j <= (j == HALF_LAST) ? '0 : j + 3'd1;
        IDLE:  if (s_valid) sample <= s_data;
        WRITE: k <= '0;
        READ: begin
          if (p_ready) begin
            if (pair_last) ptr <= (ptr == PTR_LAST) ? '0 : ptr + 4'd1;
            else           k   <= k + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    rf_we1     = 1'b0;
    rf_we2     = 1'b0;
    rf_wa1     = '0;
    rf_wa2     = '0;
    rf_wd1     = '0;
    rf_wd2     = '0;
    rf_a1      = '0;
    rf_a2      = '0;
    p_valid    = 1'b0;
    p_new      = '0;
    p_old      = '0;
    p_idx      = '0;
    p_last     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      CLEAR: begin
        // Reset lands in CLEAR; the write strobes stay quiet until rst_n releases.
        if (rst_n) begin
          rf_we1 = 1'b1;
          rf_we2 = 1'b1;
          rf_wa1 = BASE_A + {j, 1'b0};
          rf_wa2 = BASE_A + {j, 1'b1};
        end
        if (j == HALF_LAST) state_next = IDLE;
      end
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_next = WRITE;
      end
      WRITE: begin
        rf_we1     = 1'b1;
        rf_wa1     = BASE_A + ptr;
        rf_wd1     = sample;
        state_next = READ;
      end
      READ: begin
        rf_a1   = BASE_A + new_slot;
        rf_a2   = BASE_A + old_slot;
        p_valid = 1'b1;
        p_new   = rf_rd1;
        p_old   = rf_rd2;
        p_idx   = {1'b0, k};
        p_last  = pair_last;
        if (p_ready && pair_last) state_next = IDLE;
      end
      default: ;
    endcase
  end

endmodule
